// File: rtl/sprite_anim_renderer.sv
// Three-stage sprite pixel pipeline with a synchronous palette-index ROM,
// frame-synchronous position shadowing and a frame-divided animation sequencer.
module sprite_anim_renderer #(
  parameter int unsigned SPR_W       = 31,
  parameter int unsigned SPR_H       = 156,
  parameter int unsigned FRAMES      = 4,
  parameter int unsigned SCALE_SHIFT = 0,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned TRANSP_IDX  = 0,
  parameter int unsigned FRAME_DIV   = 6,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic                       vga_clk,
  input  logic                       reset_n,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       blank,
  input  logic                       frame_start,
  input  logic [9:0]                 sprite_x,
  input  logic [9:0]                 sprite_y,
  input  logic                       flip_x,
  input  logic                       anim_en,
  input  logic                       anim_loop,
  input  logic                       anim_restart,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [IDX_W-1:0]           rom_q,
  output logic                       pix_hit,
  output logic [IDX_W-1:0]           pix_index,
  output logic [$clog2(FRAMES)-1:0]  frame_idx,
  output logic                       anim_done
);

  localparam int unsigned FI_W     = $clog2(FRAMES);
  localparam int unsigned DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned BOX_W    = SPR_W << SCALE_SHIFT;
  localparam int unsigned BOX_H    = SPR_H << SCALE_SHIFT;
  localparam int unsigned FRAME_SZ = SPR_W * SPR_H;

  logic [9:0]        sx_q, sy_q;
  logic              flip_q;
  logic              hit_s1_q, hit_s2_q;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              pix_hit_q, pix_hit_d;
  logic [IDX_W-1:0]  pix_index_q, pix_index_d;
  logic [FI_W-1:0]   frame_q, frame_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              done_q, done_d;

  logic [10:0] px, py, sx, sy, dx, dy, lx, ly, lx_flip;
  logic        in_x, in_y, hit_d;
  logic [31:0] addr_full;

  // Box test and ROM address; 11-bit math keeps boxes past the screen edge from wrapping.
  always_comb begin
    px      = {1'b0, DrawX};
    py      = {1'b0, DrawY};
    sx      = {1'b0, sx_q};
    sy      = {1'b0, sy_q};
    dx      = px - sx;
    dy      = py - sy;
    in_x    = (px >= sx) && (px < (sx + 11'(BOX_W)));
    in_y    = (py >= sy) && (py < (sy + 11'(BOX_H)));
    hit_d   = blank && in_x && in_y;
    lx      = dx >> SCALE_SHIFT;
    ly      = dy >> SCALE_SHIFT;
    lx_flip = flip_q ? (11'(SPR_W - 1) - lx) : lx;
    addr_full  = 32'(frame_q) * FRAME_SZ + 32'(ly) * SPR_W + 32'(lx_flip);
    rom_addr_d = hit_d ? ADDR_W'(addr_full) : '0;
  end

  // Output stage: transparent or off-sprite pixels present index 0.
  always_comb begin
    pix_hit_d   = hit_s2_q && (rom_q != IDX_W'(TRANSP_IDX));
    pix_index_d = pix_hit_d ? rom_q : '0;
  end

  // Animation sequencer; restart overrides any step taken on the same cycle.
  always_comb begin
    frame_d = frame_q;
    div_d   = div_q;
    done_d  = done_q;
    if (anim_restart) begin
      frame_d = '0;
      div_d   = '0;
      done_d  = 1'b0;
    end else begin
      if (anim_loop) done_d = 1'b0;
      if (frame_start && anim_en) begin
        if (div_q == DIV_W'(FRAME_DIV - 1)) begin
          div_d = '0;
          if (frame_q != FI_W'(FRAMES - 1)) frame_d = frame_q + FI_W'(1);
          else if (anim_loop)               frame_d = '0;
          else                              done_d  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx_q        <= '0;
      sy_q        <= '0;
      flip_q      <= 1'b0;
      hit_s1_q    <= 1'b0;
      hit_s2_q    <= 1'b0;
      rom_addr_q  <= '0;
      pix_hit_q   <= 1'b0;
      pix_index_q <= '0;
      frame_q     <= '0;
      div_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      if (frame_start) begin
        sx_q   <= sprite_x;
        sy_q   <= sprite_y;
        flip_q <= flip_x;
      end
      hit_s1_q    <= hit_d;
      hit_s2_q    <= hit_s1_q;
      rom_addr_q  <= rom_addr_d;
      pix_hit_q   <= pix_hit_d;
      pix_index_q <= pix_index_d;
      frame_q     <= frame_d;
      div_q       <= div_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pix_hit   = pix_hit_q;
  assign pix_index = pix_index_q;
  assign frame_idx = frame_q;
  assign anim_done = done_q;

endmodule
